// File: rtl/alu_sequencer.sv
// Issuing side of the 16-bit ALU interface: 8-entry register file, one instruction
// per four cycles (IDLE -> ISSUE -> CAPTURE -> WRITE), sticky masked overflow.
module alu_sequencer #(
   parameter int DATA_W = 16,
   parameter int AW     = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                instr_valid,
   output logic                instr_ready,
   input  logic [5+3*AW-1:0]   instr,
   input  logic                ld_en,
   input  logic [AW-1:0]       ld_addr,
   input  logic [DATA_W-1:0]   ld_data,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   output logic [4:0]          alu_code,
   input  logic [DATA_W-1:0]   alu_c,
   input  logic                alu_overflow,
   output logic [DATA_W-1:0]   result,
   output logic [AW-1:0]       result_rd,
   output logic                result_valid,
   output logic                ovf_flag,
   input  logic                ovf_clear
);
   localparam int DEPTH = 1 << AW;

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, WRITE} state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [4:0]        code_q, code_d;
   logic [AW-1:0]     rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [4:0]        alu_code_q, alu_code_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_ovf_q, hold_ovf_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [AW-1:0]     result_rd_q, result_rd_d;
   logic              ovf_q, ovf_d;

   logic [4:0]        instr_code;
   logic [AW-1:0]     instr_rd, instr_ra, instr_rb;
   logic              accept;

   assign instr_code = instr[3*AW +: 5];
   assign instr_rd   = instr[2*AW +: AW];
   assign instr_ra   = instr[AW +: AW];
   assign instr_rb   = instr[0 +: AW];
   assign accept     = instr_valid && instr_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ISSUE;
         ISSUE:   state_d = CAPTURE;
         CAPTURE: state_d = WRITE;
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
         code_q      <= '0;
         rd_q        <= '0;
         ra_q        <= '0;
         rb_q        <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_code_q  <= '0;
         hold_q      <= '0;
         hold_ovf_q  <= 1'b0;
         result_q    <= '0;
         result_rd_q <= '0;
         ovf_q       <= 1'b0;
      end else begin
         regs_q      <= regs_d;
         code_q      <= code_d;
         rd_q        <= rd_d;
         ra_q        <= ra_d;
         rb_q        <= rb_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_code_q  <= alu_code_d;
         hold_q      <= hold_d;
         hold_ovf_q  <= hold_ovf_d;
         result_q    <= result_d;
         result_rd_q <= result_rd_d;
         ovf_q       <= ovf_d;
      end
   end

   always_comb begin
      regs_d      = regs_q;
      code_d      = code_q;
      rd_d        = rd_q;
      ra_d        = ra_q;
      rb_d        = rb_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_code_d  = alu_code_q;
      hold_d      = hold_q;
      hold_ovf_d  = hold_ovf_q;
      result_d    = result_q;
      result_rd_d = result_rd_q;
      ovf_d       = ovf_q;

      // A load and an accept in the same IDLE cycle both commit, so ISSUE sees the new value.
      if (state_q == IDLE && ld_en) regs_d[ld_addr] = ld_data;
      if (accept) begin
         code_d = instr_code;
         rd_d   = instr_rd;
         ra_d   = instr_ra;
         rb_d   = instr_rb;
      end

      if (state_q == ISSUE) begin
         alu_a_d    = regs_q[ra_q];
         alu_b_d    = regs_q[rb_q];
         alu_code_d = code_q;
      end

      // The ALU flags adder overflow whatever module is selected; only the adder's counts.
      if (state_q == CAPTURE) begin
         hold_d     = alu_c;
         hold_ovf_d = (alu_code_q[4:3] == 2'b00) && alu_overflow;
      end

      if (state_q == WRITE) begin
         regs_d[rd_q] = hold_q;
         result_d     = hold_q;
         result_rd_d  = rd_q;
      end

      if (ovf_clear) ovf_d = 1'b0;
      if (state_q == WRITE && hold_ovf_q) ovf_d = 1'b1;
   end

   // During WRITE the result is presented straight from the holding register so it is
   // valid alongside result_valid; afterwards the registered copy keeps it.
   always_comb begin
      instr_ready  = (state_q == IDLE) && !rst;
      result_valid = (state_q == WRITE);
      result       = (state_q == WRITE) ? hold_q : result_q;
      result_rd    = (state_q == WRITE) ? rd_q : result_rd_q;
      alu_a        = alu_a_q;
      alu_b        = alu_b_q;
      alu_code     = alu_code_q;
      ovf_flag     = ovf_q;
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: ALU stub, directed vectors, scoreboard queue
// filled at issue and drained by a monitor on every result_valid.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [13:0] instr;
   logic        ld_en;
   logic [2:0]  ld_addr;
   logic [15:0] ld_data;
   logic [15:0] alu_a, alu_b, alu_c;
   logic [4:0]  alu_code;
   logic        alu_overflow;
   logic [15:0] result;
   logic [2:0]  result_rd;
   logic        result_valid;
   logic        ovf_flag;
   logic        ovf_clear;

   typedef struct {
      logic [15:0] data;
      logic [2:0]  rd;
   } exp_t;

   exp_t sb_q[$];
   int   valid_cycs[$];
   int   tests_run = 0;
   int   tests_failed = 0;
   int   cyc = 0;
   int   accept_cyc = 0;
   int   last_valid_cyc = 0;

   alu_sequencer #(.DATA_W(16), .AW(3)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code),
      .alu_c(alu_c), .alu_overflow(alu_overflow),
      .result(result), .result_rd(result_rd), .result_valid(result_valid),
      .ovf_flag(ovf_flag), .ovf_clear(ovf_clear)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ALU stub: 00000 add with signed overflow, 01000 AND with overflow forced high.
   always_comb begin
      logic [15:0] sum;
      sum          = alu_a + alu_b;
      alu_c        = 16'h0000;
      alu_overflow = 1'b0;
      case (alu_code)
         5'b00000: begin
            alu_c        = sum;
            alu_overflow = (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]);
         end
         5'b01000: begin
            alu_c        = alu_a & alu_b;
            alu_overflow = 1'b1;
         end
         default: ;
      endcase
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && result_valid) begin
         exp_t e;
         valid_cycs.push_back(cyc);
         last_valid_cyc = cyc;
         if (sb_q.size() == 0) begin
            checkOutput("unexpected result_valid", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            checkOutput("result", {16'h0, result}, {16'h0, e.data});
            checkOutput("result_rd", {29'h0, result_rd}, {29'h0, e.rd});
         end
      end
   end

   // Called on a negedge; returns on the negedge of the ISSUE cycle.
   task automatic applyStimulus(input logic [4:0] code, input logic [2:0] rd,
                                input logic [2:0] ra, input logic [2:0] rb,
                                input logic [15:0] exp_data, input bit expect_result,
                                input bit keep_valid);
      int waited = 0;
      while (!instr_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!instr_ready) begin
         checkOutput("instr_ready timeout", 32'd0, 32'd1);
         instr_valid = 1'b0;
         return;
      end
      instr       = {code, rd, ra, rb};
      instr_valid = 1'b1;
      if (expect_result) sb_q.push_back('{exp_data, rd});
      accept_cyc = cyc + 1;
      @(negedge clk);
      if (!keep_valid) instr_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int n = 0;
      while ((sb_q.size() != 0 || !instr_ready) && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (sb_q.size() != 0) begin
         checkOutput("scoreboard drain", sb_q.size(), 32'd0);
         sb_q.delete();
      end
   endtask

   task automatic loadReg(input logic [2:0] addr, input logic [15:0] data);
      ld_en   = 1'b1;
      ld_addr = addr;
      ld_data = data;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   // AND a register with itself into r7: the result is the register's value.
   task automatic readReg(input logic [2:0] addr, input logic [15:0] exp_data);
      applyStimulus(5'b01000, 3'd7, addr, addr, exp_data, 1'b1, 1'b0);
      waitIdle();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      instr_valid = 1'b0;
      instr = '0;
      ld_en = 1'b0;
      ld_addr = '0;
      ld_data = '0;
      ovf_clear = 1'b0;

      repeat (3) @(negedge clk);
      checkOutput("reset instr_ready", {31'h0, instr_ready}, 32'd0);
      checkOutput("reset result_valid", {31'h0, result_valid}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post-reset alu_a", {16'h0, alu_a}, 32'd0);
      checkOutput("post-reset alu_b", {16'h0, alu_b}, 32'd0);
      checkOutput("post-reset alu_code", {27'h0, alu_code}, 32'd0);
      checkOutput("post-reset result", {16'h0, result}, 32'd0);
      checkOutput("post-reset result_rd", {29'h0, result_rd}, 32'd0);
      checkOutput("post-reset ovf_flag", {31'h0, ovf_flag}, 32'd0);
      checkOutput("post-reset instr_ready", {31'h0, instr_ready}, 32'd1);

      // Basic add with handshake timing: busy for three cycles, valid in the third.
      loadReg(3'd1, 16'h0003);
      loadReg(3'd2, 16'h0004);
      applyStimulus(5'b00000, 3'd3, 3'd1, 3'd2, 16'h0007, 1'b1, 1'b0);
      checkOutput("ready low in ISSUE", {31'h0, instr_ready}, 32'd0);
      @(negedge clk);
      checkOutput("ready low in CAPTURE", {31'h0, instr_ready}, 32'd0);
      checkOutput("no valid in CAPTURE", {31'h0, result_valid}, 32'd0);
      @(negedge clk);
      checkOutput("ready low in WRITE", {31'h0, instr_ready}, 32'd0);
      checkOutput("valid in WRITE", {31'h0, result_valid}, 32'd1);
      @(negedge clk);
      checkOutput("ready back in IDLE", {31'h0, instr_ready}, 32'd1);
      checkOutput("valid is one pulse", {31'h0, result_valid}, 32'd0);
      checkOutput("accept-to-valid cycles", last_valid_cyc - accept_cyc, 32'd2);
      checkOutput("result held after WRITE", {16'h0, result}, 32'h0007);
      waitIdle();
      readReg(3'd3, 16'h0007);

      // Signed overflow sets the sticky flag; the logic module's overflow is masked.
      loadReg(3'd1, 16'h7FFF);
      loadReg(3'd2, 16'h0001);
      applyStimulus(5'b00000, 3'd4, 3'd1, 3'd2, 16'h8000, 1'b1, 1'b0);
      waitIdle();
      checkOutput("ovf after add overflow", {31'h0, ovf_flag}, 32'd1);
      applyStimulus(5'b01000, 3'd6, 3'd1, 3'd2, 16'h0001, 1'b1, 1'b0);
      waitIdle();
      checkOutput("ovf kept through logic op", {31'h0, ovf_flag}, 32'd1);
      ovf_clear = 1'b1;
      @(negedge clk);
      ovf_clear = 1'b0;
      checkOutput("ovf cleared", {31'h0, ovf_flag}, 32'd0);
      applyStimulus(5'b01000, 3'd6, 3'd1, 3'd2, 16'h0001, 1'b1, 1'b0);
      waitIdle();
      checkOutput("logic op leaves ovf clear", {31'h0, ovf_flag}, 32'd0);

      // Load and accept on the same edge: ISSUE reads the freshly loaded r5.
      ld_en   = 1'b1;
      ld_addr = 3'd5;
      ld_data = 16'h00AA;
      applyStimulus(5'b01000, 3'd5, 3'd5, 3'd5, 16'h00AA, 1'b1, 1'b0);
      ld_en = 1'b0;
      @(negedge clk);
      checkOutput("same-cycle alu_a", {16'h0, alu_a}, 32'h00AA);
      checkOutput("same-cycle alu_b", {16'h0, alu_b}, 32'h00AA);
      checkOutput("same-cycle alu_code", {27'h0, alu_code}, 32'h08);
      waitIdle();
      readReg(3'd5, 16'h00AA);

      // Loads while busy are dropped; a clear coincident with an overflow WRITE loses.
      applyStimulus(5'b00000, 3'd6, 3'd1, 3'd2, 16'h8000, 1'b1, 1'b0);
      ld_en   = 1'b1;
      ld_addr = 3'd0;
      ld_data = 16'h1234;
      @(negedge clk);
      @(negedge clk);
      ovf_clear = 1'b1;
      @(negedge clk);
      ovf_clear = 1'b0;
      ld_en = 1'b0;
      checkOutput("set beats clear", {31'h0, ovf_flag}, 32'd1);
      ovf_clear = 1'b1;
      @(negedge clk);
      ovf_clear = 1'b0;
      checkOutput("clear in IDLE", {31'h0, ovf_flag}, 32'd0);
      waitIdle();
      readReg(3'd0, 16'h0000);
      checkOutput("alu_a holds after WRITE", {16'h0, alu_a}, 32'h0000);

      // Back-to-back with instr_valid held high, including read-after-write chains.
      loadReg(3'd1, 16'h0010);
      loadReg(3'd2, 16'h0022);
      valid_cycs.delete();
      applyStimulus(5'b00000, 3'd3, 3'd1, 3'd2, 16'h0032, 1'b1, 1'b1);
      applyStimulus(5'b01000, 3'd4, 3'd1, 3'd2, 16'h0000, 1'b1, 1'b1);
      applyStimulus(5'b00000, 3'd5, 3'd3, 3'd1, 16'h0042, 1'b1, 1'b1);
      applyStimulus(5'b00000, 3'd6, 3'd5, 3'd5, 16'h0084, 1'b1, 1'b0);
      waitIdle();
      checkOutput("back-to-back pulse count", valid_cycs.size(), 32'd4);
      if (valid_cycs.size() == 4) begin
         for (int i = 1; i < 4; i++)
            checkOutput("back-to-back spacing", valid_cycs[i] - valid_cycs[i-1], 32'd4);
      end
      readReg(3'd6, 16'h0084);

      // Reset in CAPTURE aborts the instruction and clears the register file.
      applyStimulus(5'b00000, 3'd4, 3'd1, 3'd2, 16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("ready low during rst", {31'h0, instr_ready}, 32'd0);
      checkOutput("no valid during rst", {31'h0, result_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("abort result", {16'h0, result}, 32'd0);
      checkOutput("abort ovf_flag", {31'h0, ovf_flag}, 32'd0);
      checkOutput("abort instr_ready", {31'h0, instr_ready}, 32'd1);
      checkOutput("abort alu_a", {16'h0, alu_a}, 32'd0);
      readReg(3'd4, 16'h0000);
      readReg(3'd1, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
